// File: rtl/nasti_write_arbiter.sv
// nasti_write_arbiter: round-robin sharing of one NASTI write port (AW/W/B)
// between NUM_MASTERS requesters, one transaction at a time. W and B stay
// locked to the granted master until its B handshake. s_w_last comes from a
// local beat counter, so the master's own w_last is never used.

// Per-master gating: a master sees ready/b_valid only while it holds the grant
// and the arbiter is in the matching channel phase.
module nasti_wa_port (
   input  logic aw_sel,
   input  logic w_sel,
   input  logic b_sel,
   input  logic s_aw_ready,
   input  logic s_w_ready,
   input  logic s_b_valid,
   output logic m_aw_ready,
   output logic m_w_ready,
   output logic m_b_valid
);
   assign m_aw_ready = aw_sel & s_aw_ready;
   assign m_w_ready  = w_sel  & s_w_ready;
   assign m_b_valid  = b_sel  & s_b_valid;
endmodule

module nasti_write_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ID_WIDTH    = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   // master AW
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]       m_aw_id,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_aw_addr,
   input  logic [NUM_MASTERS*8-1:0]              m_aw_len,
   input  logic [NUM_MASTERS*3-1:0]              m_aw_size,
   input  logic [NUM_MASTERS*2-1:0]              m_aw_burst,
   input  logic [NUM_MASTERS-1:0]                m_aw_valid,
   output logic [NUM_MASTERS-1:0]                m_aw_ready,
   // master W
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_w_data,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_w_strb,
   input  logic [NUM_MASTERS-1:0]                m_w_last,
   input  logic [NUM_MASTERS-1:0]                m_w_valid,
   output logic [NUM_MASTERS-1:0]                m_w_ready,
   // master B
   output logic [NUM_MASTERS*ID_WIDTH-1:0]       m_b_id,
   output logic [NUM_MASTERS*2-1:0]              m_b_resp,
   output logic [NUM_MASTERS-1:0]                m_b_valid,
   input  logic [NUM_MASTERS-1:0]                m_b_ready,
   // slave AW
   output logic [ID_WIDTH-1:0]                   s_aw_id,
   output logic [ADDR_WIDTH-1:0]                 s_aw_addr,
   output logic [7:0]                            s_aw_len,
   output logic [2:0]                            s_aw_size,
   output logic [1:0]                            s_aw_burst,
   output logic                                  s_aw_valid,
   input  logic                                  s_aw_ready,
   // slave W
   output logic [DATA_WIDTH-1:0]                 s_w_data,
   output logic [DATA_WIDTH/8-1:0]               s_w_strb,
   output logic                                  s_w_last,
   output logic                                  s_w_valid,
   input  logic                                  s_w_ready,
   // slave B
   input  logic [ID_WIDTH-1:0]                   s_b_id,
   input  logic [1:0]                            s_b_resp,
   input  logic                                  s_b_valid,
   output logic                                  s_b_ready
);

   localparam int GW     = $clog2(NUM_MASTERS);
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        w_cnt_q, w_cnt_d;

   logic              pick_found;
   logic [GW-1:0]     pick_idx;
   logic [NUM_MASTERS-1:0] gnt_oh;
   logic              st_aw, st_w, st_b;
   logic              unused_w_last;

   // Master-side w_last is deliberately ignored; beats are counted locally.
   assign unused_w_last = ^m_w_last;

   assign st_aw = (state_q == S_AW);
   assign st_w  = (state_q == S_W);
   assign st_b  = (state_q == S_B);

   // Round-robin pick: first requester at or above rr_ptr, wrapping at N.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
         if (!pick_found && m_aw_valid[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx[GW-1:0];
         end
      end
   end

   // One-hot view of the current grant for the per-master gating.
   always_comb begin
      gnt_oh          = '0;
      gnt_oh[grant_q] = 1'b1;
   end

   // Slave-side fields always follow the granted slice (slice 0 out of reset).
   assign s_aw_id    = m_aw_id   [grant_q*ID_WIDTH   +: ID_WIDTH];
   assign s_aw_addr  = m_aw_addr [grant_q*ADDR_WIDTH +: ADDR_WIDTH];
   assign s_aw_len   = m_aw_len  [grant_q*8          +: 8];
   assign s_aw_size  = m_aw_size [grant_q*3          +: 3];
   assign s_aw_burst = m_aw_burst[grant_q*2          +: 2];
   assign s_w_data   = m_w_data  [grant_q*DATA_WIDTH +: DATA_WIDTH];
   assign s_w_strb   = m_w_strb  [grant_q*STRB_W     +: STRB_W];

   assign s_aw_valid = st_aw & m_aw_valid[grant_q];
   assign s_w_valid  = st_w  & m_w_valid[grant_q];
   assign s_w_last   = st_w  & (w_cnt_q == len_q);
   assign s_b_ready  = st_b  & m_b_ready[grant_q];

   // B id/resp are broadcast; only m_b_valid says who the response is for.
   assign m_b_id   = {NUM_MASTERS{s_b_id}};
   assign m_b_resp = {NUM_MASTERS{s_b_resp}};

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
      nasti_wa_port u_port (
         .aw_sel     (st_aw & gnt_oh[i]),
         .w_sel      (st_w  & gnt_oh[i]),
         .b_sel      (st_b  & gnt_oh[i]),
         .s_aw_ready (s_aw_ready),
         .s_w_ready  (s_w_ready),
         .s_b_valid  (s_b_valid),
         .m_aw_ready (m_aw_ready[i]),
         .m_w_ready  (m_w_ready[i]),
         .m_b_valid  (m_b_valid[i])
      );
   end

   // Transaction sequencing: arbitrate, forward AW, count W beats, wait for B.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      len_d    = len_q;
      w_cnt_d  = w_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = S_AW;
            end
         end
         S_AW: begin
            if (s_aw_valid && s_aw_ready) begin
               len_d   = s_aw_len;
               w_cnt_d = '0;
               state_d = S_W;
            end
         end
         S_W: begin
            if (s_w_valid && s_w_ready) begin
               w_cnt_d = w_cnt_q + 8'd1;
               if (s_w_last) state_d = S_B;
            end
         end
         S_B: begin
            if (s_b_valid && s_b_ready) begin
               if (int'(grant_q) == NUM_MASTERS - 1) rr_ptr_d = '0;
               else                                  rr_ptr_d = grant_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         len_q    <= '0;
         w_cnt_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         len_q    <= len_d;
         w_cnt_q  <= w_cnt_d;
      end
   end

endmodule

// File: tb/tb_nasti_write_arbiter.sv
// Directed bench for nasti_write_arbiter (2 masters): a per-cycle vector table
// for grant order, lock-out and reset, plus hand-written transactions with
// a small slave model for beat ordering and backpressure.
module tb_nasti_write_arbiter;

   logic         clk = 1'b0;
   logic         rstn;
   logic [3:0]   m_aw_id;
   logic [63:0]  m_aw_addr;
   logic [15:0]  m_aw_len;
   logic [5:0]   m_aw_size;
   logic [3:0]   m_aw_burst;
   logic [1:0]   m_aw_valid, m_aw_ready;
   logic [127:0] m_w_data;
   logic [15:0]  m_w_strb;
   logic [1:0]   m_w_last, m_w_valid, m_w_ready;
   logic [3:0]   m_b_id, m_b_resp;
   logic [1:0]   m_b_valid, m_b_ready;
   logic [1:0]   s_aw_id;
   logic [31:0]  s_aw_addr;
   logic [7:0]   s_aw_len;
   logic [2:0]   s_aw_size;
   logic [1:0]   s_aw_burst;
   logic         s_aw_valid, s_aw_ready;
   logic [63:0]  s_w_data;
   logic [7:0]   s_w_strb;
   logic         s_w_last, s_w_valid, s_w_ready;
   logic [1:0]   s_b_id, s_b_resp;
   logic         s_b_valid, s_b_ready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nasti_write_arbiter #(.NUM_MASTERS(2), .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
      .clk(clk), .rstn(rstn),
      .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
      .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
      .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
      .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
      .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready)
   );

   // One table row = inputs for one cycle plus the outputs expected in it.
   // exp packs {s_aw_valid, s_w_valid, s_w_last, s_b_ready,
   //            m_aw_ready[1:0], m_w_ready[1:0], m_b_valid[1:0]}.
   typedef struct {
      logic       rstn;
      logic [1:0] awv, wv, bready;
      logic       saw_r, sw_r, sb_v;
      logic [9:0] exp;
      int         gnt;   // granted master whose AW fields should show, or -1
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] awv, input logic [1:0] wv,
                      input logic [1:0] br, input logic sar, input logic swr,
                      input logic sbv, input logic [9:0] exp, input int gnt);
      vec_t v;
      v.rstn = r; v.awv = awv; v.wv = wv; v.bready = br;
      v.saw_r = sar; v.sw_r = swr; v.sb_v = sbv; v.exp = exp; v.gnt = gnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {s_aw_valid, s_w_valid, s_w_last, s_b_ready, m_aw_ready, m_w_ready, m_b_valid};
   endfunction

   // Full handshake-level transaction on master m with an optional random
   // backpressure; the slave model returns B once it has all len+1 beats.
   task automatic run_txn(input int m, input int len, input bit rnd);
      int         aw_hs = 0, w_sent = 0, s_beats = 0, lasts = 0, bad = 0, cyc = 0;
      bit         done = 0, aw_pend = 1;
      logic [1:0] id_cap = 2'd0;
      logic [31:0] exp_addr;
      logic [7:0]  l8;
      l8 = len[7:0];
      exp_addr = (m == 0) ? 32'h100 : 32'h200;
      m_aw_len[m*8 +: 8] = l8;
      while (!done && cyc < 300) begin
         m_aw_valid = '0;
         if (aw_pend) m_aw_valid[m] = 1'b1;
         m_w_valid = '0;
         if (w_sent <= len) m_w_valid[m] = 1'b1;
         m_w_data = '0;
         m_w_data[m*64 +: 64] = 64'hD000 + 64'(w_sent);
         s_aw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_w_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         m_b_ready  = 2'b11;
         m_b_ready[m] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_b_valid  = (s_beats == len + 1);
         s_b_id     = id_cap;
         s_b_resp   = 2'b00;
         @(negedge clk);
         if (s_aw_valid && s_aw_ready) begin
            aw_hs++;
            id_cap = s_aw_id;
            if (s_aw_addr != exp_addr || s_aw_len != l8) bad++;
         end
         if (m_aw_valid[m] && m_aw_ready[m]) aw_pend = 0;
         if (s_w_valid && s_w_ready) begin
            if (s_w_data != 64'hD000 + 64'(s_beats)) bad++;
            if (s_w_last != (s_beats == len)) bad++;
            if (s_w_last) lasts++;
            s_beats++;
         end
         if (m_w_valid[m] && m_w_ready[m]) w_sent++;
         if (m_b_valid[1-m] || m_aw_ready[1-m] || m_w_ready[1-m]) bad++;
         if (m_b_valid[m] && m_b_ready[m]) begin
            done = 1;
            if (m_b_id[m*2 +: 2] != id_cap || m_b_id[(1-m)*2 +: 2] != id_cap ||
                m_b_resp[m*2 +: 2] != 2'b00) bad++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk($sformatf("txn%0d_len%0d_done", m, len), 64'(done), 64'd1);
      chk($sformatf("txn%0d_len%0d_aw_count", m, len), 64'(aw_hs), 64'd1);
      chk($sformatf("txn%0d_len%0d_beats", m, len), 64'(s_beats), 64'(len + 1));
      chk($sformatf("txn%0d_len%0d_last_count", m, len), 64'(lasts), 64'd1);
      chk($sformatf("txn%0d_len%0d_field_errors", m, len), 64'(bad), 64'd0);
      m_aw_valid = '0; m_w_valid = '0; s_b_valid = 1'b0; m_b_ready = '0;
      s_aw_ready = 1'b0; s_w_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_addr;
      logic [7:0]  exp_len;
      logic [1:0]  exp_id;
      rstn = 1'b0;
      m_aw_id    = {2'd2, 2'd1};
      m_aw_addr  = {32'h200, 32'h100};
      m_aw_len   = {8'd0, 8'd3};
      m_aw_size  = {3'd3, 3'd3};
      m_aw_burst = {2'd1, 2'd1};
      m_aw_valid = '0;
      m_w_data   = {64'hBBBB_0001, 64'hAAAA_0001};
      m_w_strb   = '1;
      m_w_last   = '0;
      m_w_valid  = '0;
      m_b_ready  = '0;
      s_aw_ready = 1'b0; s_w_ready = 1'b0;
      s_b_id = 2'd0; s_b_resp = 2'd0; s_b_valid = 1'b0;

      // single master 0, len 3, w_last tied low
      add(1, 2'b01, 2'b00, 2'b00, 1, 0, 0, 10'b0000_00_00_00, -1);
      add(1, 2'b01, 2'b00, 2'b00, 1, 0, 0, 10'b1000_01_00_00,  0);
      add(1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 10'b0100_00_00_00, -1);
      add(1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0110_00_01_00, -1);
      add(1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 10'b0000_00_00_01, -1);
      add(1, 2'b00, 2'b00, 2'b01, 0, 0, 1, 10'b0001_00_00_01, -1);
      add(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 10'b0000_00_00_00, -1);
      // reset, then both request together; master 1 pushes W early
      add(0, 2'b11, 2'b00, 2'b00, 1, 0, 0, 10'b0000_00_00_00, -1);
      add(1, 2'b11, 2'b10, 2'b00, 0, 0, 0, 10'b0000_00_00_00, -1);
      add(1, 2'b11, 2'b10, 2'b00, 0, 0, 0, 10'b1000_00_00_00,  0);
      add(1, 2'b11, 2'b10, 2'b00, 1, 0, 0, 10'b1000_01_00_00,  0);
      add(1, 2'b10, 2'b11, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b10, 2'b11, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b10, 2'b11, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(1, 2'b10, 2'b11, 2'b00, 0, 1, 0, 10'b0110_00_01_00, -1);
      add(1, 2'b10, 2'b10, 2'b11, 0, 0, 1, 10'b0001_00_00_01, -1);
      // master 0 keeps requesting; rr_ptr=1 so master 1 goes next (len 0)
      add(1, 2'b11, 2'b10, 2'b00, 0, 0, 0, 10'b0000_00_00_00, -1);
      add(1, 2'b11, 2'b10, 2'b00, 1, 0, 0, 10'b1000_10_00_00,  1);
      add(1, 2'b01, 2'b11, 2'b00, 0, 1, 0, 10'b0110_00_10_00, -1);
      add(1, 2'b01, 2'b00, 2'b10, 0, 0, 1, 10'b0001_00_00_10, -1);
      // back to master 0, then reset mid-burst
      add(1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 10'b0000_00_00_00, -1);
      add(1, 2'b01, 2'b00, 2'b00, 1, 0, 0, 10'b1000_01_00_00,  0);
      add(1, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0100_00_01_00, -1);
      add(0, 2'b00, 2'b01, 2'b00, 0, 1, 0, 10'b0000_00_00_00, -1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outputs", 64'(outs()), 64'd0);
      chk("reset_aw_addr_slice0", 64'(s_aw_addr), 64'h100);
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         rstn       = tbl[i].rstn;
         m_aw_valid = tbl[i].awv;
         m_w_valid  = tbl[i].wv;
         m_b_ready  = tbl[i].bready;
         s_aw_ready = tbl[i].saw_r;
         s_w_ready  = tbl[i].sw_r;
         s_b_valid  = tbl[i].sb_v;
         @(negedge clk);
         chk($sformatf("vec%0d_handshakes", i), 64'(outs()), 64'(tbl[i].exp));
         if (tbl[i].gnt >= 0) begin
            exp_addr = (tbl[i].gnt == 0) ? 32'h100 : 32'h200;
            exp_len  = (tbl[i].gnt == 0) ? 8'd3 : 8'd0;
            exp_id   = (tbl[i].gnt == 0) ? 2'd1 : 2'd2;
            chk($sformatf("vec%0d_aw_fields", i), {s_aw_addr, s_aw_len, s_aw_id},
                {exp_addr, exp_len, exp_id});
         end
         @(posedge clk); #1;
      end

      // still held in reset after the mid-burst assertion
      m_aw_valid = '0; m_w_valid = '0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0;
      @(negedge clk);
      chk("midburst_reset_outputs", 64'(outs()), 64'd0);
      chk("midburst_reset_w_data_slice0", s_w_data, m_w_data[63:0]);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // fresh len=1 on master 1 after reset, then len=0 under backpressure
      run_txn(1, 1, 1'b0);
      repeat (3) run_txn(0, 0, 1'b1);
      run_txn(1, 2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
